// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store port and the data-memory responder.
// The core drives the master side and the memory drives the slave side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with a valid/ready request/response handshake and a fixed
// access latency; stores use byte strobes, misaligned or out-of-range accesses report an error.
module dmem_responder #(
    parameter int  DEPTH   = 256,
    parameter int  LATENCY = 2,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  counter;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        we_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  wstrb_p0;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        commit_we;
    logic        commit_err;
    logic [31:0] commit_addr;
    logic [31:0] commit_wdata;
    logic [3:0]  commit_wstrb;

    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> (IDX_W + 2)) != 32'd0);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    // With LATENCY=1 the commit happens on the acceptance edge itself, before the
    // capture registers hold the request, so the live bus is used in IDLE.
    always_comb begin
        accept = bus.req_valid && req_ready_q;
        if (state == IDLE) begin
            commit_we    = bus.req_we;
            commit_addr  = bus.req_addr;
            commit_wdata = bus.req_wdata;
            commit_wstrb = bus.req_wstrb;
        end else begin
            commit_we    = we_p0;
            commit_addr  = addr_p0;
            commit_wdata = wdata_p0;
            commit_wstrb = wstrb_p0;
        end
        commit_err = addr_err(commit_addr);
        enter_resp = ((state == BUSY) && (counter == 4'd1)) || (accept && (LATENCY == 1));
    end

    // Stage p0: request capture at acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= bus.req_we;
            addr_p0  <= bus.req_addr;
            wdata_p0 <= bus.req_wdata;
            wstrb_p0 <= bus.req_wstrb;
        end
    end

    // Stage p1: array write on the edge entering RESP
    always_ff @(posedge clk) begin
        if (enter_resp && !rst && commit_we && !commit_err) begin
            for (int b = 0; b < 4; b++) begin
                if (commit_wstrb[b]) begin
                    mem[addr_idx(commit_addr)][8*b +: 8] <= commit_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        if (LATENCY > 1) begin
                            state   <= BUSY;
                            counter <= 4'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    counter <= counter - 4'd1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // The load reads the array on the same edge, so earlier completed stores are visible.
            if (enter_resp) begin
                state       <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= commit_err;
                rsp_rdata_q <= (!commit_we && !commit_err) ? mem[addr_idx(commit_addr)] : 32'd0;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder, three instances (LATENCY 2, 4 and 1)
// checked against a word-array reference model.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_d;
    logic [2:0]  req_valid_d;
    logic [2:0]  req_we_d;
    logic [2:0]  rsp_ready_d;
    logic [31:0] req_addr_d  [3];
    logic [31:0] req_wdata_d [3];
    logic [3:0]  req_wstrb_d [3];

    wire  [2:0]  req_ready_w;
    wire  [2:0]  rsp_valid_w;
    wire  [2:0]  rsp_err_w;
    wire  [31:0] rsp_rdata_w [3];

    logic [31:0] model [3][256];
    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder_if bus ();
        assign bus.req_valid   = req_valid_d[g];
        assign bus.req_we      = req_we_d[g];
        assign bus.req_addr    = req_addr_d[g];
        assign bus.req_wdata   = req_wdata_d[g];
        assign bus.req_wstrb   = req_wstrb_d[g];
        assign bus.rsp_ready   = rsp_ready_d[g];
        assign req_ready_w[g]  = bus.req_ready;
        assign rsp_valid_w[g]  = bus.rsp_valid;
        assign rsp_err_w[g]    = bus.rsp_err;
        assign rsp_rdata_w[g]  = bus.rsp_rdata;

        dmem_responder #(.DEPTH(256), .LATENCY((g == 0) ? 2 : (g == 1) ? 4 : 1)) dut (
            .clk (clk),
            .rst (rst_d[g]),
            .bus (bus)
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 4 : 1;
    endfunction

    // A request errors when not word aligned or beyond the 256-word (1 KiB) array.
    function automatic bit m_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input int k, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                          output logic [31:0] rdata);
        int n;
        bit exp_e;
        logic [31:0] exp_d;
        exp_e = m_err(addr);
        exp_d = (!we && !exp_e) ? model[k][addr / 4] : 32'd0;
        @(negedge clk);
        req_valid_d[k] = 1'b1;
        req_we_d[k]    = we;
        req_addr_d[k]  = addr;
        req_wdata_d[k] = wdata;
        req_wstrb_d[k] = strb;
        rsp_ready_d[k] = 1'b0;
        n = 0;
        while (!req_ready_w[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_accept", req_ready_w[k], 1'b1);
        @(posedge clk);
        #1;
        req_valid_d[k] = 1'b0;
        req_we_d[k]    = 1'($urandom);
        req_addr_d[k]  = $urandom;
        req_wdata_d[k] = $urandom;
        req_wstrb_d[k] = 4'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid_w[k] && n < 40);
        chk("latency", n, lat_of(k));
        chk("rsp_err", rsp_err_w[k], exp_e);
        chk("rsp_rdata", rsp_rdata_w[k], exp_d);
        chk("req_ready_in_resp", req_ready_w[k], 1'b0);
        rdata = rsp_rdata_w[k];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid_w[k], 1'b1);
            chk("hold_rdata", rsp_rdata_w[k], exp_d);
            chk("hold_err", rsp_err_w[k], exp_e);
            chk("hold_req_ready", req_ready_w[k], 1'b0);
        end
        rsp_ready_d[k] = 1'b1;
        @(negedge clk);
        chk("req_ready_after_hs", req_ready_w[k], 1'b1);
        chk("rsp_valid_after_hs", rsp_valid_w[k], 1'b0);
        rsp_ready_d[k] = 1'b0;
        if (we && !exp_e) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[k][addr / 4][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic [31:0] a;
    int n;

    initial begin
        rst_d       = 3'b111;
        req_valid_d = 3'b000;
        req_we_d    = 3'b000;
        rsp_ready_d = 3'b000;
        for (int k = 0; k < 3; k++) begin
            req_addr_d[k]  = 32'd0;
            req_wdata_d[k] = 32'd0;
            req_wstrb_d[k] = 4'd0;
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req_ready", req_ready_w[0], 1'b0);
            chk("rst_rsp_valid", rsp_valid_w[0], 1'b0);
            chk("rst_rsp_rdata", rsp_rdata_w[0], 32'd0);
            chk("rst_rsp_err", rsp_err_w[0], 1'b0);
        end
        rst_d = 3'b000;
        @(posedge clk);
        #1;
        chk("ready_after_release", req_ready_w[0], 1'b1);

        // Store/load round trip
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, rd);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, 0, rd);
        chk("load_0x10", rd, 32'hDEADBEEF);

        // Byte strobes and empty strobe
        do_txn(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 0, rd);
        do_txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'b0000, 0, rd);
        chk("strobe_0101", rd, 32'h11BB33DD);
        do_txn(0, 1'b1, 32'h20, 32'h99999999, 4'b0000, 0, rd);
        do_txn(0, 1'b0, 32'h20, 32'h0, 4'b0000, 0, rd);
        chk("strobe_0000", rd, 32'h11BB33DD);

        // Error responses
        do_txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, 0, rd);
        do_txn(0, 1'b0, 32'h402, 32'h0, 4'b0000, 0, rd);
        do_txn(0, 1'b1, 32'h400, 32'h12121212, 4'b1111, 0, rd);
        do_txn(0, 1'b1, 32'h2, 32'h34343434, 4'b1111, 0, rd);
        do_txn(0, 1'b0, 32'h0, 32'h0, 4'b0000, 0, rd);
        chk("err_store_no_alias", rd, 32'hCAFEF00D);

        // Backpressure on a load
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, 5, rd);
        chk("backpressure_load", rd, 32'hDEADBEEF);

        // Randomized traffic on words 0..15
        for (int i = 0; i < 16; i++) do_txn(0, 1'b1, 32'(i * 4), $urandom, 4'b1111, 0, rd);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                1:       a = 32'h400 + 32'($urandom_range(0, 255) * 4);
                2:       a = 32'h8000_0000 | 32'($urandom_range(0, 15) * 4);
                default: a = 32'($urandom_range(0, 15) * 4);
            endcase
            do_txn(0, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2), rd);
        end

        // LATENCY=4: reset two cycles into a store drops it
        do_txn(1, 1'b1, 32'h8, 32'h12345678, 4'b1111, 0, rd);
        @(negedge clk);
        req_valid_d[1] = 1'b1;
        req_we_d[1]    = 1'b1;
        req_addr_d[1]  = 32'h8;
        req_wdata_d[1] = 32'h55;
        req_wstrb_d[1] = 4'b1111;
        @(posedge clk);
        #1;
        req_valid_d[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_d[1] = 1'b1;
        #1;
        chk("midrst_rsp_valid", rsp_valid_w[1], 1'b0);
        chk("midrst_req_ready", req_ready_w[1], 1'b0);
        chk("midrst_rsp_rdata", rsp_rdata_w[1], 32'd0);
        chk("midrst_rsp_err", rsp_err_w[1], 1'b0);
        repeat (3) @(negedge clk);
        rst_d[1] = 1'b0;
        do_txn(1, 1'b0, 32'h8, 32'h0, 4'b0000, 0, rd);
        chk("midrst_old_value", rd, 32'h12345678);

        // LATENCY=4: reset while in RESP keeps the committed store
        do_txn(1, 1'b1, 32'hC, 32'hABCD0123, 4'b1111, 0, rd);
        @(negedge clk);
        req_valid_d[1] = 1'b1;
        req_we_d[1]    = 1'b1;
        req_addr_d[1]  = 32'hC;
        req_wdata_d[1] = 32'h77;
        req_wstrb_d[1] = 4'b1111;
        rsp_ready_d[1] = 1'b0;
        @(posedge clk);
        #1;
        req_valid_d[1] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid_w[1] && n < 40);
        chk("resp_rst_latency", n, 4);
        #1;
        rst_d[1] = 1'b1;
        #1;
        chk("resp_rst_valid", rsp_valid_w[1], 1'b0);
        model[1][3] = 32'h77;
        repeat (2) @(negedge clk);
        rst_d[1] = 1'b0;
        do_txn(1, 1'b0, 32'hC, 32'h0, 4'b0000, 0, rd);
        chk("resp_rst_committed", rd, 32'h77);

        // LATENCY=1
        do_txn(2, 1'b1, 32'h3C, 32'h0BADF00D, 4'b1111, 0, rd);
        do_txn(2, 1'b0, 32'h3C, 32'h0, 4'b0000, 1, rd);
        chk("lat1_load", rd, 32'h0BADF00D);
        for (int i = 0; i < 4; i++) do_txn(2, 1'b1, 32'(i * 4), $urandom, 4'b1111, 0, rd);
        for (int i = 0; i < 12; i++) begin
            do_txn(2, 1'($urandom), 32'($urandom_range(0, 3) * 4), $urandom, 4'($urandom),
                   $urandom_range(0, 2), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the pipelined RISC-V core: the responder end of the core's load/store port (memrw / address / data_write / data_read).
- Replaces the zero-latency, combinational-read data memory used by the single-cycle core.
- Adds a valid/ready request/response handshake with a configurable access latency, so the 5-stage pipeline must stall on loads and stores.
- Word-organised storage with byte-lane write strobes; out-of-range and misaligned requests are flagged as errors.

Parameters:
- DEPTH, 256, number of 32-bit words; power of 2, 4..65536.
- LATENCY, 2, cycles from request acceptance to response valid; 1..15.
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load (the core's memrw).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte-lane enables for stores; bit i controls byte i.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request was out of range or misaligned.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE, counter=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array is not cleared.
- req_ready=1 in IDLE while rst=0, i.e. from the first cycle after reset deassertion. req_ready=0 in every other state.
- FSM states: IDLE, BUSY, RESP.
  - IDLE -> BUSY on req_valid&&req_ready when LATENCY>1; counter loads LATENCY-1.
  - IDLE -> RESP directly on acceptance when LATENCY=1.
  - BUSY: counter decrements every cycle; moves to RESP on the edge where counter==1.
  - RESP: rsp_valid=1; outputs are held stable until rsp_ready=1. RESP -> IDLE on rsp_valid&&rsp_ready.
- Latency: rsp_valid rises exactly LATENCY cycles after the acceptance edge.
  - No same-cycle new acceptance on the response handshake cycle.
  - Minimum spacing between transactions is LATENCY+1 cycles.
- Request capture: req_we, req_addr, req_wdata and req_wstrb are registered at acceptance. Inputs may change afterwards without effect.
- Address decode:
  - idx = addr[IDX_W+1:2].
  - err = (addr[1:0]!=0) || (addr[31:IDX_W+2]!=0).
- Commit on the edge entering RESP:
  - Store, no error: byte i of mem[idx] is written with wdata byte i where wstrb[i]=1; other bytes are unchanged. rsp_rdata=0.
  - wstrb=0000: no bytes change; this is not an error.
  - Load, no error: rsp_rdata = mem[idx], sampled on that same edge, so it includes all previously completed stores. The full word is returned; byte/half extraction is done in the core.
  - Error (load or store): no array write, rsp_rdata=0, rsp_err=1.
  - rsp_err=0 on every non-error response.
- Reset mid-operation (BUSY or RESP): the transaction is dropped.
  - A store not yet in RESP is not committed.
  - A store already committed stays in memory.
- req_valid held during BUSY/RESP is ignored. The request is accepted only after the return to IDLE.
- No combinational path from request inputs to response outputs.

Test Plan:
- Reset then idle, LATENCY=2: rst pulse high for 3 cycles -> during reset req_ready=0, rsp_valid=0; req_ready=1 on the first cycle after release.
- Store then load: store addr 0x10, wdata 0xDEADBEEF, wstrb 1111; then load 0x10 -> rsp_valid exactly 2 cycles after each acceptance; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte strobes: word 0x20 holds 0x11223344; store wdata 0xAABBCCDD, wstrb 0101; load 0x20 -> 0x11BB33DD. wstrb 0000 leaves the word unchanged.
- Errors, DEPTH=256: load 0x402 -> rsp_err=1, rsp_rdata=0. Store 0x400 -> rsp_err=1, and a subsequent load of 0x0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; req_ready=1 the cycle after the rsp_ready handshake.
- Reset mid-store, LATENCY=4: assert rst 2 cycles after acceptance of a store of 0x55 to 0x8 -> outputs clear immediately; a later load of 0x8 returns the old value.
- LATENCY=1: load -> rsp_valid rises in the cycle right after acceptance.
